// File: rtl/mem2d_arbiter.sv
// Round-robin arbiter for two requesters sharing a BANKS x DEPTH memory.
// After reset, a sweep loads every entry with its linear index before any requests are served.
module mem2d_arbiter #(
    parameter int DW    = 8,
    parameter int BANKS = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [2:0]    bank0,
    input  logic [2:0]    bank1,
    input  logic [2:0]    idx0,
    input  logic [2:0]    idx1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy
);
    localparam int N  = BANKS * DEPTH;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] K_LAST    = AW'(N - 1);
    localparam logic [AW-1:0] DEPTH_MUL = AW'(DEPTH);
    localparam logic [3:0]    BANKS_LIM = 4'(BANKS);
    localparam logic [3:0]    DEPTH_LIM = 4'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_reg;
    logic [AW-1:0] k_reg;
    logic          last_reg;
    logic          rsp_valid_reg;
    logic          rsp_id_reg;
    logic          rsp_err_reg;
    logic [DW-1:0] rsp_data_reg;

    logic [DW-1:0] mem [N];

    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [1:0]    in_range;
    logic [1:0]    gnt_vec;
    logic [2:0]    bank_vec  [2];
    logic [2:0]    idx_vec   [2];
    logic [DW-1:0] wdata_vec [2];
    logic [AW-1:0] addr_vec  [2];

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign bank_vec[0]  = bank0;
    assign bank_vec[1]  = bank1;
    assign idx_vec[0]   = idx0;
    assign idx_vec[1]   = idx1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign in_range[gi] = ({1'b0, bank_vec[gi]} < BANKS_LIM) &&
                                  ({1'b0, idx_vec[gi]}  < DEPTH_LIM);
            // Modular arithmetic is exact whenever the access is in range.
            assign addr_vec[gi] = AW'(bank_vec[gi]) * DEPTH_MUL + AW'(idx_vec[gi]);
            // Under contention the side that did not win last time is served.
            assign gnt_vec[gi]  = (state_reg == RUN) && req_vec[gi] &&
                                  (!req_vec[1 - gi] || (last_reg != 1'(gi)));
        end
    endgenerate

    logic          gnt_any;
    logic          sel;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign gnt_any   = |gnt_vec;
    assign sel       = gnt_vec[1];
    assign mem_we    = (state_reg == INIT) || (gnt_any && we_vec[sel] && in_range[sel]);
    assign mem_waddr = (state_reg == INIT) ? k_reg : addr_vec[sel];
    assign mem_wdata = (state_reg == INIT) ? DW'(k_reg) : wdata_vec[sel];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg     <= INIT;
            k_reg         <= '0;
            last_reg      <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= gnt_any;
            if (state_reg == INIT) begin
                k_reg <= k_reg + AW'(1);
                if (k_reg == K_LAST) begin
                    state_reg <= RUN;
                    k_reg     <= '0;
                end
            end else if (gnt_any) begin
                last_reg    <= sel;
                rsp_id_reg  <= sel;
                rsp_err_reg <= !in_range[sel];
                if (!in_range[sel]) begin
                    rsp_data_reg <= '0;
                end else if (we_vec[sel]) begin
                    rsp_data_reg <= wdata_vec[sel];
                end else begin
                    rsp_data_reg <= mem[addr_vec[sel]];
                end
            end
        end
    end

    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg == INIT);
endmodule

// File: doc/mem2d_arbiter.md
# mem2d_arbiter

Two-requester round-robin arbiter and controller for a shared 2-D byte memory of BANKS x DEPTH entries of DW bits, default 2 x 4 x 8. After reset it runs an initialization sweep that loads every entry with its linear index. It then serves one read or write per cycle from two requesters, with bounds checking on both address fields. It sits between testbench or datapath masters and the shared array, replacing direct multi-driver access to the array.

## Interface
- DW, 8, data width
- BANKS, 2, number of banks (first dimension), 1..8
- DEPTH, 4, entries per bank (second dimension), 1..8

- clk  in  1  clock, rising edge
- nreset  in  1  asynchronous active-low reset
- req0 / req1  in  1  request from requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- bank0 / bank1  in  3  bank index (first dimension)
- idx0 / idx1  in  3  entry index (second dimension)
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  grant, combinational, at most one high
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DW  read data or echoed write data
- rsp_err  out  1  out-of-range access
- busy  out  1  initialization in progress

## Operation
- FSM states:
  - INIT (reset state): counter k walks 0..BANKS*DEPTH-1, one entry per cycle. Entry (k/DEPTH, k%DEPTH) gets k[DW-1:0]. On the last write it moves to RUN. busy=1 throughout.
  - RUN: busy=0. The FSM stays in RUN until reset.
- Arbitration (RUN only):
  - A single requesting side is granted.
  - If both request, the side not granted most recently wins.
  - The last-grant register resets to 1, so requester 0 wins the first contention.
  - Gaps in requests do not reset the pointer.
- Handshake: a requester holds req, we, bank, idx and wdata stable until it sees its gnt high at a rising edge. The transfer occurs at that edge. A requester may keep req high for back-to-back transfers.
- Range check: an access is out of range if bank >= BANKS or idx >= DEPTH.
  - Out-of-range write: dropped; memory unchanged.
  - Out-of-range read: returns 0.
  - Either case sets rsp_err=1.
- Response, one cycle after the grant edge:
  - rsp_valid=1, rsp_id=granted requester.
  - Read: rsp_data = entry value before any same-edge write (only one access per edge, so no conflict).
  - Write: rsp_data = wdata, or 0 if out of range.
- Data hazards: a write at edge N followed by a read of the same entry at edge N+1 returns the new value.
- Reset mid-operation: all outputs go to their reset values immediately. Any pending response is discarded. The FSM returns to INIT and all prior writes are overwritten by the sweep.

## Timing
- Reset values:
  - gnt0=0, gnt1=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=1.
  - Internal: last-grant=1, k=0.
- INIT lasts exactly BANKS*DEPTH cycles after nreset deasserts (8 by default). busy falls at the edge that completes the last write. gnt may assert in the first RUN cycle.
- Throughput: one transfer per cycle. Latency: grant edge to rsp_valid edge is 1 cycle.
- gnt depends combinationally on req and on registered state only, never on rsp.
- rsp_valid is low in every cycle with no grant on the preceding edge. rsp_data and rsp_err hold their last values while rsp_valid=0.

## Test plan
- Reset release:
  - Required: busy=1 for 8 cycles, then 0.
  - Then read all 8 entries via req0: rsp_data 0x00..0x07 in order, rsp_err=0, rsp_id=0.
- Contention:
  - Stimulus: req0 and req1 held high as reads of (0,1) and (1,1).
  - Required: grants alternate gnt0, gnt1, gnt0, …, starting with gnt0. Responses alternate rsp_id 0/1 with data 0x01/0x05.
- Write/read:
  - Stimulus: req0 writes 0xF3 to (0,3); next cycle req1 reads (0,3).
  - Required: first response rsp_data=0xF3 with rsp_err=0, then rsp_id=1 with rsp_data=0xF3.
- Out of range:
  - Stimulus: write 0xC1 to (3,0); write 0xC3 to (4,2); read (0,4).
  - Required: each gives rsp_err=1 and rsp_data=0x00. A sweep of all 8 entries is unchanged.
- Reset mid-stream:
  - Stimulus: nreset pulsed low while gnt1=1 and a response is pending.
  - Required: rsp_valid=0 and busy=1 immediately. The sweep restarts. After it ends, (0,3) reads 0x03, not 0xF3.
